// File: rtl/adpll_seq_if.sv
// ============================================================================
// Module      : adpll_seq_if
// Description : ADPLL register-port bundle. The sequencer drives the request
//               side (valid/address/wdata/wstrb) through the master modport,
//               the ADPLL returns rdata/ready through the slave modport.
//               wstrb = 1 marks a write, 0 a read; rdata is captured on the
//               posedge that samples ready = 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adpll_seq_if #(
    parameter int ADPLL_ADDR_W = 4,
    parameter int ADPLL_DATA_W = 32
);
    logic                    valid;
    logic [ADPLL_ADDR_W-1:0] address;
    logic [ADPLL_DATA_W-1:0] wdata;
    logic                    wstrb;
    logic [1:0]              rdata;
    logic                    ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

`default_nettype wire

// File: rtl/adpll_seq.sv
// ============================================================================
// Module      : adpll_seq
// Description : ADPLL channel-acquisition sequencer. A start pulse with a BLE
//               channel (0..39) soft-resets the ADPLL, programs FCW and mode,
//               enables it, then alternates SAT/LOCK status reads until
//               LOCK_CNT consecutive lock reads are seen (LOCKED), saturation
//               is reported, or the timeout counter saturates. Failure paths
//               disable the ADPLL before returning to IDLE.
// Ports       : clk, rst (async, active-high)
//               start/abort    - request pulses
//               chan/mode      - sampled with an accepted start
//               port           - ADPLL register port (adpll_seq_if.master)
//               busy/locked    - status
//               fail/fail_code - sticky error, 1=bad chan 2=timeout 3=sat
// Options     : `define ADPLL_SEQ_RELOCK_EN keeps polling ADPLL_LOCK while
//               LOCKED and re-acquires on loss of lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adpll_seq #(
    parameter int TIMEOUT_W    = 16,
    parameter int LOCK_CNT     = 4,
    parameter int ADPLL_ADDR_W = 4,   // must match the connected interface
    parameter int ADPLL_DATA_W = 32,  // must match the connected interface
    parameter int FCWW         = 26
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       start,
    input  wire logic       abort,
    input  wire logic [5:0] chan,
    input  wire logic [1:0] mode,
    adpll_seq_if.master     port,
    output logic            busy,
    output logic            locked,
    output logic            fail,
    output logic [1:0]      fail_code
);

    localparam int SW = $clog2(LOCK_CNT + 1);

    localparam logic [ADPLL_ADDR_W-1:0] REG_SOFT_RST = ADPLL_ADDR_W'(0);
    localparam logic [ADPLL_ADDR_W-1:0] REG_FCW      = ADPLL_ADDR_W'(1);
    localparam logic [ADPLL_ADDR_W-1:0] REG_MODE     = ADPLL_ADDR_W'(2);
    localparam logic [ADPLL_ADDR_W-1:0] REG_EN       = ADPLL_ADDR_W'(3);
    localparam logic [ADPLL_ADDR_W-1:0] REG_LOCK     = ADPLL_ADDR_W'(4);
    localparam logic [ADPLL_ADDR_W-1:0] REG_SAT      = ADPLL_ADDR_W'(5);

    // FCW = 2402 MHz base plus 2 MHz per channel, in FCW units.
    localparam logic [FCWW-1:0] FCW_BASE = FCWW'(32'h0258_8000);
    localparam logic [FCWW-1:0] FCW_STEP = FCWW'(32'h0000_8000);

    localparam logic [1:0] CODE_NONE = 2'd0;
    localparam logic [1:0] CODE_CHAN = 2'd1;
    localparam logic [1:0] CODE_TMO  = 2'd2;
    localparam logic [1:0] CODE_SAT  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SRST1  = 4'd1,
        ST_SRST0  = 4'd2,
        ST_WFCW   = 4'd3,
        ST_WMODE  = 4'd4,
        ST_WEN    = 4'd5,
        ST_POLL   = 4'd6,
        ST_LOCKED = 4'd7,
        ST_DIS    = 4'd8
    } state_t;

    state_t                  state_q,      state_d;
    logic                    valid_q,      valid_d;
    logic [ADPLL_ADDR_W-1:0] address_q,    address_d;
    logic [ADPLL_DATA_W-1:0] wdata_q,      wdata_d;
    logic                    wstrb_q,      wstrb_d;
    logic                    busy_q,       busy_d;
    logic                    locked_q,     locked_d;
    logic                    fail_q,       fail_d;
    logic [1:0]              fail_code_q,  fail_code_d;
    logic [5:0]              chan_q,       chan_d;
    logic [1:0]              mode_q,       mode_d;
    logic                    abort_pend_q, abort_pend_d;
    logic [1:0]              dis_code_q,   dis_code_d;
    logic                    rd_lock_q,    rd_lock_d;   // next POLL read: 0=SAT, 1=LOCK
    logic [TIMEOUT_W-1:0]    tmo_q,        tmo_d;
    logic [SW-1:0]           streak_q,     streak_d;
    // An access still in flight belongs to a state we already left; let it
    // finish without advancing the new state.
    logic                    stale_q,      stale_d;

    logic [FCWW-1:0]         fcw;
    logic [ADPLL_ADDR_W-1:0] acc_addr;
    logic [ADPLL_DATA_W-1:0] acc_data;
    logic                    acc_wr;
    logic                    abort_now;
    logic                    start_ok;
    logic                    rd_one;

    assign fcw    = FCW_BASE + FCWW'(chan_q) * FCW_STEP;
    assign rd_one = (port.rdata == 2'd1);

    // Aborts act only once the FCW stage is reached; earlier ones wait in
    // abort_pend_q so the soft-reset pair is never split.
    assign abort_now = (abort || abort_pend_q) &&
                       (state_q == ST_WFCW || state_q == ST_WMODE ||
                        state_q == ST_WEN  || state_q == ST_POLL  ||
                        state_q == ST_LOCKED);

    assign start_ok = start && !abort &&
                      (state_q == ST_IDLE || state_q == ST_LOCKED);

    // Access issued by the current state once its gap cycle is over.
    always_comb begin
        acc_addr = REG_SOFT_RST;
        acc_data = '0;
        acc_wr   = 1'b1;
        case (state_q)
            ST_SRST1:  acc_data = ADPLL_DATA_W'(1);
            ST_WFCW:   begin acc_addr = REG_FCW;  acc_data = ADPLL_DATA_W'(fcw);    end
            ST_WMODE:  begin acc_addr = REG_MODE; acc_data = ADPLL_DATA_W'(mode_q); end
            ST_WEN:    begin acc_addr = REG_EN;   acc_data = ADPLL_DATA_W'(1);      end
            ST_DIS:    acc_addr = REG_EN;
            ST_POLL:   begin acc_addr = rd_lock_q ? REG_LOCK : REG_SAT; acc_wr = 1'b0; end
            ST_LOCKED: begin acc_addr = REG_LOCK; acc_wr = 1'b0; end
            default:   ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        fail_d       = fail_q;
        fail_code_d  = fail_code_q;
        chan_d       = chan_q;
        mode_d       = mode_q;
        abort_pend_d = abort_pend_q;
        dis_code_d   = dis_code_q;
        rd_lock_d    = rd_lock_q;
        tmo_d        = tmo_q;
        streak_d     = streak_q;
        stale_d      = stale_q;

        if (abort && state_q != ST_IDLE && state_q != ST_DIS)
            abort_pend_d = 1'b1;
        if (state_q == ST_POLL && !(&tmo_q))
            tmo_d = tmo_q + 1'b1;

        case (state_q)
            ST_SRST1, ST_SRST0, ST_WFCW, ST_WMODE, ST_WEN, ST_DIS: begin
                if (valid_q) begin
                    if (port.ready) begin
                        valid_d = 1'b0;
                        if (stale_q) begin
                            stale_d = 1'b0;
                        end else if (abort_now) begin
                            state_d      = ST_DIS;
                            dis_code_d   = CODE_NONE;
                            abort_pend_d = 1'b0;
                        end else begin
                            case (state_q)
                                ST_SRST1: state_d = ST_SRST0;
                                ST_SRST0: state_d = ST_WFCW;
                                ST_WFCW:  state_d = ST_WMODE;
                                ST_WMODE: state_d = ST_WEN;
                                ST_WEN: begin
                                    state_d   = ST_POLL;
                                    tmo_d     = '0;
                                    streak_d  = '0;
                                    rd_lock_d = 1'b0;
                                end
                                default: begin
                                    state_d      = ST_IDLE;
                                    abort_pend_d = 1'b0;
                                    if (dis_code_q != CODE_NONE) begin
                                        fail_d      = 1'b1;
                                        fail_code_d = dis_code_q;
                                    end
                                end
                            endcase
                        end
                    end
                end else if (abort_now) begin
                    state_d      = ST_DIS;
                    dis_code_d   = CODE_NONE;
                    abort_pend_d = 1'b0;
                end else begin
                    valid_d   = 1'b1;
                    address_d = acc_addr;
                    wdata_d   = acc_data;
                    wstrb_d   = acc_wr;
                end
            end

            ST_POLL: begin
                if (valid_q) begin
                    if (port.ready) begin
                        valid_d   = 1'b0;
                        rd_lock_d = !rd_lock_q;
                        if (abort_now) begin
                            state_d      = ST_DIS;
                            dis_code_d   = CODE_NONE;
                            abort_pend_d = 1'b0;
                        end else if (!rd_lock_q) begin
                            if (rd_one) begin
                                state_d    = ST_DIS;
                                dis_code_d = CODE_SAT;
                            end
                        end else if (rd_one) begin
                            if (streak_q == SW'(LOCK_CNT - 1))
                                state_d = ST_LOCKED;
                            else
                                streak_d = streak_q + 1'b1;
                        end else begin
                            streak_d = '0;
                        end
                    end
                end else if (abort_now) begin
                    state_d      = ST_DIS;
                    dis_code_d   = CODE_NONE;
                    abort_pend_d = 1'b0;
                end else if (&tmo_q) begin
                    state_d    = ST_DIS;
                    dis_code_d = CODE_TMO;
                end else begin
                    valid_d   = 1'b1;
                    address_d = acc_addr;
                    wdata_d   = acc_data;
                    wstrb_d   = acc_wr;
                end
            end

            ST_LOCKED: begin
                if (abort_now) begin
                    state_d      = ST_DIS;
                    dis_code_d   = CODE_NONE;
                    abort_pend_d = 1'b0;
                    if (valid_q) begin
                        valid_d = !port.ready;
                        stale_d = !port.ready;
                    end
                end
`ifdef ADPLL_SEQ_RELOCK_EN
                else if (valid_q) begin
                    if (port.ready) begin
                        valid_d = 1'b0;
                        if (!rd_one) begin
                            state_d   = ST_POLL;
                            tmo_d     = '0;
                            streak_d  = '0;
                            rd_lock_d = 1'b0;
                        end
                    end
                end else begin
                    valid_d   = 1'b1;
                    address_d = acc_addr;
                    wdata_d   = acc_data;
                    wstrb_d   = acc_wr;
                end
`endif
            end

            default: ;
        endcase

        // Accepted start overrides whatever IDLE/LOCKED decided above.
        if (start_ok) begin
            fail_d      = 1'b0;
            fail_code_d = CODE_NONE;
            if (chan > 6'd39) begin
                fail_d      = 1'b1;
                fail_code_d = CODE_CHAN;
            end else begin
                chan_d       = chan;
                mode_d       = mode;
                state_d      = ST_SRST1;
                abort_pend_d = 1'b0;
                if (valid_q) begin
                    stale_d = !port.ready;
                end else begin
                    valid_d   = 1'b1;
                    address_d = REG_SOFT_RST;
                    wdata_d   = ADPLL_DATA_W'(1);
                    wstrb_d   = 1'b1;
                end
            end
        end

        busy_d   = (state_d != ST_IDLE) && (state_d != ST_LOCKED);
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            wstrb_q      <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= '0;
            chan_q       <= '0;
            mode_q       <= '0;
            abort_pend_q <= 1'b0;
            dis_code_q   <= '0;
            rd_lock_q    <= 1'b0;
            tmo_q        <= '0;
            streak_q     <= '0;
            stale_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
            chan_q       <= chan_d;
            mode_q       <= mode_d;
            abort_pend_q <= abort_pend_d;
            dis_code_q   <= dis_code_d;
            rd_lock_q    <= rd_lock_d;
            tmo_q        <= tmo_d;
            streak_q     <= streak_d;
            stale_q      <= stale_d;
        end
    end

    assign port.valid   = valid_q;
    assign port.address = address_q;
    assign port.wdata   = wdata_q;
    assign port.wstrb   = wstrb_q;
    assign busy         = busy_q;
    assign locked       = locked_q;
    assign fail         = fail_q;
    assign fail_code    = fail_code_q;

endmodule

`default_nettype wire

// File: tb/tb_adpll_seq.sv
// ============================================================================
// Module      : tb_adpll_seq
// Description : Directed bench for adpll_seq with a small ADPLL port model
//               (ready registered on negedge, SAT/LOCK status driven by the
//               bench) and a write log checked against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adpll_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort;
    logic [5:0] chan;
    logic [1:0] mode;
    logic       busy, locked, fail;
    logic [1:0] fail_code;

    logic       lock_st, sat_st;

    int total = 0;
    int bad   = 0;

    adpll_seq_if #(.ADPLL_ADDR_W(4), .ADPLL_DATA_W(32)) bus ();

    adpll_seq #(
        .TIMEOUT_W   (8),
        .LOCK_CNT    (4),
        .ADPLL_ADDR_W(4),
        .ADPLL_DATA_W(32),
        .FCWW        (26)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .chan     (chan),
        .mode     (mode),
        .port     (bus),
        .busy     (busy),
        .locked   (locked),
        .fail     (fail),
        .fail_code(fail_code)
    );

    always #5 clk = ~clk;

    // ADPLL port model.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            bus.ready <= 1'b0;
            bus.rdata <= 2'd0;
        end else begin
            bus.ready <= bus.valid;
            if (bus.address == 4'd5)      bus.rdata <= {1'b0, sat_st};
            else if (bus.address == 4'd4) bus.rdata <= {1'b0, lock_st};
            else                          bus.rdata <= 2'd0;
        end
    end

    // Monitor: write log, lock-read streak, valid pulses, first read cycle.
    logic [3:0]  log_a[$];
    logic [31:0] log_d[$];
    int  cyc = 0;
    int  valid_pulses = 0;
    int  streak = 0;
    int  first_rd = -1;
    bit  prev_valid = 1'b0;
    bit  ever_locked = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.valid && !prev_valid) valid_pulses = valid_pulses + 1;
        prev_valid = bus.valid;
        if (bus.valid && !bus.wstrb && first_rd < 0) first_rd = cyc;
        if (bus.valid && bus.ready) begin
            if (bus.wstrb) begin
                log_a.push_back(bus.address);
                log_d.push_back(bus.wdata);
            end else if (bus.address == 4'd4) begin
                streak = (bus.rdata == 2'd1) ? streak + 1 : 0;
            end
        end
        if (locked) ever_locked = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] c, input logic [1:0] m);
        chan  = c;
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_log();
        log_a.delete();
        log_d.delete();
        first_rd = -1;
    endtask

    task automatic chk_last_dis(input string tag);
        chk({tag, "_last_addr"}, 32'(log_a[log_a.size()-1]), 32'd3);
        chk({tag, "_last_data"}, log_d[log_a.size()-1], 32'd0);
    endtask

    logic [3:0]  exp_a [5];
    logic [31:0] exp_d [5];
    int t0, p;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; chan = '0; mode = '0;
        lock_st = 1'b0; sat_st = 1'b0;
        exp_a = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3};
        exp_d = '{32'd1, 32'd0, 32'h0262_0000, 32'd1, 32'd1};

        repeat (3) tick();
        chk("rst_valid",  32'(bus.valid), 32'd0);
        chk("rst_busy",   32'(busy),      32'd0);
        chk("rst_locked", 32'(locked),    32'd0);
        chk("rst_fail",   32'(fail),      32'd0);
        chk("rst_code",   32'(fail_code), 32'd0);
        rst = 1'b0;
        tick();

        // Normal acquisition on channel 19, lock appears after 100 cycles.
        clear_log();
        do_start(6'd19, 2'd1);
        t0 = cyc;
        chk("acq_busy",   32'(busy),        32'd1);
        chk("acq_valid1", 32'(bus.valid),   32'd1);
        chk("acq_addr1",  32'(bus.address), 32'd0);
        chk("acq_data1",  bus.wdata,        32'd1);
        repeat (100) tick();
        lock_st = 1'b1;
        for (int i = 0; i < 60 && !locked; i++) tick();
        chk("acq_locked", 32'(locked), 32'd1);
        chk("acq_busy0",  32'(busy),   32'd0);
        chk("acq_streak", 32'(streak), 32'd4);
        chk("acq_first_rd_lat", 32'(first_rd - t0), 32'd11);
        chk("acq_nwrites", 32'(log_a.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("acq_wr%0d_addr", i), 32'(log_a[i]), 32'(exp_a[i]));
            chk($sformatf("acq_wr%0d_data", i), log_d[i], exp_d[i]);
        end
`ifndef ADPLL_SEQ_RELOCK_EN
        p = valid_pulses;
        repeat (20) tick();
        chk("locked_quiet", 32'(valid_pulses), 32'(p));
`endif

        // Abort while locked: disable, back to IDLE, no fail.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("ablk_busy",   32'(busy),   32'd0);
        chk("ablk_locked", 32'(locked), 32'd0);
        chk("ablk_fail",   32'(fail),   32'd0);
        chk_last_dis("ablk");
        lock_st = 1'b0;

        // Bad channel.
        p = valid_pulses;
        do_start(6'd40, 2'd0);
        chk("badch_fail", 32'(fail),      32'd1);
        chk("badch_code", 32'(fail_code), 32'd1);
        chk("badch_busy", 32'(busy),      32'd0);
        repeat (5) tick();
        chk("badch_novalid", 32'(valid_pulses), 32'(p));

        // Timeout (TIMEOUT_W = 8), lock never asserted.
        clear_log();
        do_start(6'd0, 2'd0);
        t0 = cyc;
        chk("tmo_fail_cleared", 32'(fail), 32'd0);
        for (int i = 0; i < 400 && busy; i++) tick();
        chk("tmo_busy",   32'(busy),      32'd0);
        chk("tmo_fail",   32'(fail),      32'd1);
        chk("tmo_code",   32'(fail_code), 32'd2);
        chk("tmo_window", 32'((cyc - t0) >= 260 && (cyc - t0) <= 280), 32'd1);
        chk_last_dis("tmo");

        // Saturation on channel 39.
        clear_log();
        sat_st = 1'b1;
        ever_locked = 1'b0;
        do_start(6'd39, 2'd2);
        for (int i = 0; i < 60 && busy; i++) tick();
        chk("sat_fail",   32'(fail),        32'd1);
        chk("sat_code",   32'(fail_code),   32'd3);
        chk("sat_nolock", 32'(ever_locked), 32'd0);
        chk("sat_fcw",    log_d[2],         32'h026C_0000);
        chk("sat_mode",   log_d[3],         32'd2);
        chk_last_dis("sat");
        sat_st = 1'b0;

        // Abort while the FCW write is outstanding.
        clear_log();
        do_start(6'd5, 2'd0);
        repeat (4) tick();
        chk("abf_valid", 32'(bus.valid),   32'd1);
        chk("abf_addr",  32'(bus.address), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("abf_busy",    32'(busy),         32'd0);
        chk("abf_fail",    32'(fail),         32'd0);
        chk("abf_nwrites", 32'(log_a.size()), 32'd4);
        chk("abf_fcw",     log_d[2],          32'h025B_0000);
        chk_last_dis("abf");

        // abort and start together in IDLE: start is dropped.
        p = valid_pulses;
        chan = 6'd3; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abst_busy", 32'(busy), 32'd0);
        tick();
        chk("abst_novalid", 32'(valid_pulses), 32'(p));

`ifdef ADPLL_SEQ_RELOCK_EN
        // Loss of lock while LOCKED, then re-acquire.
        lock_st = 1'b1;
        do_start(6'd10, 2'd1);
        for (int i = 0; i < 60 && !locked; i++) tick();
        chk("rl_locked", 32'(locked), 32'd1);
        repeat (5) tick();
        lock_st = 1'b0;
        for (int i = 0; i < 3 && locked; i++) tick();
        chk("rl_drop", 32'(locked), 32'd0);
        chk("rl_busy", 32'(busy),   32'd1);
        lock_st = 1'b1;
        for (int i = 0; i < 60 && !locked; i++) tick();
        chk("rl_relocked", 32'(locked), 32'd1);
        chk("rl_streak",   32'(streak), 32'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("rl_abort_busy", 32'(busy), 32'd0);
        lock_st = 1'b0;
`endif

        // Async reset in the middle of a POLL access.
        do_start(6'd7, 2'd1);
        repeat (15) tick();
        for (int i = 0; i < 4 && !bus.valid; i++) tick();
        chk("rstm_pre_valid", 32'(bus.valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstm_valid",  32'(bus.valid), 32'd0);
        chk("rstm_busy",   32'(busy),      32'd0);
        chk("rstm_locked", 32'(locked),    32'd0);
        chk("rstm_fail",   32'(fail),      32'd0);
        chk("rstm_code",   32'(fail_code), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
